// File: rtl/verdict_collector.sv
// rtl/verdict_collector.sv - captures active monitor streams into a record FIFO and serializes them as header+payload words
// Optional feature macro: VERDICT_TIMESTAMP_EN (timestamp counter and header [63:32]).
module verdict_collector #(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [63:0] output_0,
    input  logic signed [63:0] output_1,
    input  logic signed [63:0] output_2,
    input  logic signed [63:0] output_3,
    input  logic               output_0_aktv,
    input  logic               output_1_aktv,
    input  logic               output_2_aktv,
    input  logic               output_3_aktv,
    output logic [63:0]        rec_data,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic               rec_last,
    output logic               overflow,
    output logic [15:0]        drop_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [3:0]      rem_q, rem_d;
    logic            overflow_q;
    logic [15:0]     drop_q;

    logic [3:0]      mask_mem [DEPTH];
    logic [255:0]    val_mem  [DEPTH];

    logic [3:0]      aktv;
    logic            capture, full, push, drop, pop, rem_last;
    logic [1:0]      idx;
    logic [255:0]    head_vals;
    logic [31:0]     head_ts;

    assign aktv    = {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv};
    assign capture = !rst && en && (aktv != 4'd0);
    // Fullness is judged on the registered count, so a pop in the same cycle cannot rescue a capture.
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign push    = capture && !full;
    assign drop    = capture && full;

`ifdef VERDICT_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= 32'd0;
        end else if (en) begin
            ts_q <= ts_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_q] <= ts_q;
        end
    end

    assign head_ts = ts_mem[rd_ptr_q];
`else
    assign head_ts = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_q] <= aktv;
            val_mem[wr_ptr_q]  <= {output_3, output_2, output_1, output_0};
        end
    end

    assign head_vals = val_mem[rd_ptr_q];
    assign rem_last  = ((rem_q & (rem_q - 4'd1)) == 4'd0);

    always_comb begin
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rem_q[i]) idx = 2'(i);
        end
    end

    assign pop     = (state_q == S_PAYLOAD) && rec_ready && rem_last;
    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        rec_valid = 1'b0;
        rec_last  = 1'b0;
        rec_data  = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_HEADER;
            end
            S_HEADER: begin
                rec_valid = 1'b1;
                rec_data  = {head_ts, 28'd0, mask_mem[rd_ptr_q]};
                if (rec_ready) begin
                    rem_d   = mask_mem[rd_ptr_q];
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                rec_valid = 1'b1;
                rec_last  = rem_last;
                rec_data  = head_vals[{idx, 6'd0} +: 64];
                if (rec_ready) begin
                    rem_d = rem_q & (rem_q - 4'd1);
                    // A record captured this very cycle still counts, giving back-to-back headers.
                    if (rem_last) state_d = (count_d != '0) ? S_HEADER : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rem_q      <= 4'd0;
            overflow_q <= 1'b0;
            drop_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_verdict_collector.sv
// tb/tb_verdict_collector.sv - randomized and directed scoreboard bench for verdict_collector
module tb_verdict_collector;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, en, rec_ready;
    logic [3:0]  aktv;
    logic [63:0] vals [4];
    logic [63:0] rec_data;
    logic        rec_valid, rec_last, overflow;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    verdict_collector #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .output_0(vals[0]), .output_1(vals[1]), .output_2(vals[2]), .output_3(vals[3]),
        .output_0_aktv(aktv[0]), .output_1_aktv(aktv[1]),
        .output_2_aktv(aktv[2]), .output_3_aktv(aktv[3]),
        .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_last(rec_last), .overflow(overflow), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          rec_pushed = 0;
    int          rec_done = 0;
    int          exp_drops = 0;
    logic [31:0] ts_model = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr_ts(input logic [31:0] t);
`ifdef VERDICT_TIMESTAMP_EN
        return t;
`else
        return 32'd0;
`endif
    endfunction

    // Reference: a record is a header then one word per active output, lowest index first.
    task automatic push_rec(input logic [3:0] m, input logic [31:0] t);
        int n = 0;
        exp_q.push_back('{data: {hdr_ts(t), 28'd0, m}, last: 1'b0});
        for (int i = 0; i < 4; i++) if (m[i]) n++;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                n--;
                exp_q.push_back('{data: vals[i], last: (n == 0)});
            end
        end
        rec_pushed++;
    endtask

    task automatic cycle(input bit model_on);
        if (model_on && en && aktv != 4'd0) begin
            if (rec_pushed - rec_done >= DEPTH) begin
                if (exp_drops < 65535) exp_drops++;
            end else begin
                push_rec(aktv, ts_model);
            end
        end
        if (en) ts_model = ts_model + 32'd1;
        @(posedge clk);
        #1;
    endtask

    logic        hold = 1'b0;
    logic [63:0] hold_data;
    logic        hold_last;

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else if (rec_valid) begin
            if (hold) begin
                check("stable_data", rec_data, hold_data);
                check("stable_last", {63'd0, rec_last}, {63'd0, hold_last});
            end
            if (rec_ready) begin
                hold = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none", rec_data);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word_data", rec_data, w.data);
                    check("word_last", {63'd0, rec_last}, {63'd0, w.last});
                    if (w.last) rec_done++;
                end
            end else begin
                hold      = 1'b1;
                hold_data = rec_data;
                hold_last = rec_last;
            end
        end else if (hold) begin
            check("valid_held", {63'd0, rec_valid}, 64'd1);
            hold = 1'b0;
        end
    end

    task automatic idle_inputs();
        en   = 1'b0;
        aktv = 4'd0;
    endtask

    task automatic drain();
        int k = 0;
        idle_inputs();
        rec_ready = 1'b1;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        ts_model   = 32'd0;
        exp_q.delete();
        rec_pushed = 0;
        rec_done   = 0;
        exp_drops  = 0;
    endtask

    initial begin
        rst = 1'b1;
        rec_ready = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) vals[i] = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        check("rst_valid", {63'd0, rec_valid}, 64'd0);
        check("rst_last", {63'd0, rec_last}, 64'd0);
        check("rst_data", rec_data, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_drops", {48'd0, drop_count}, 64'd0);

        // Single output record at timestamp 10.
        rec_ready = 1'b1;
        en = 1'b1;
        repeat (10) cycle(1'b0);
        aktv = 4'b0001;
        vals[0] = 64'd5;
`ifdef VERDICT_TIMESTAMP_EN
        exp_q.push_back('{data: 64'h0000000A_00000001, last: 1'b0});
`else
        exp_q.push_back('{data: 64'h00000000_00000001, last: 1'b0});
`endif
        exp_q.push_back('{data: 64'd5, last: 1'b1});
        rec_pushed++;
        cycle(1'b0);
        idle_inputs();
        check("valid_latency", {63'd0, rec_valid}, 64'd0);
        drain();

        // All four outputs active.
        en = 1'b1;
        aktv = 4'hF;
        for (int i = 0; i < 4; i++) vals[i] = 64'(i + 1);
        exp_q.push_back('{data: {hdr_ts(ts_model), 28'd0, 4'hF}, last: 1'b0});
        exp_q.push_back('{data: 64'd1, last: 1'b0});
        exp_q.push_back('{data: 64'd2, last: 1'b0});
        exp_q.push_back('{data: 64'd3, last: 1'b0});
        exp_q.push_back('{data: 64'd4, last: 1'b1});
        rec_pushed++;
        cycle(1'b0);
        drain();

        // Value churn without a capture condition, then a capture to expose the frozen timestamp.
        en = 1'b1;
        aktv = 4'd0;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 4; i++) vals[i] = {$urandom, $urandom};
            cycle(1'b1);
        end
        en = 1'b0;
        aktv = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 4; i++) vals[i] = {$urandom, $urandom};
            cycle(1'b1);
        end
        check("no_capture_valid", {63'd0, rec_valid}, 64'd0);
        en = 1'b1;
        aktv = 4'b0110;
        cycle(1'b1);
        drain();

        // Reset between header and payload aborts the record.
        en = 1'b1;
        aktv = 4'b0100;
        vals[2] = 64'h1234;
        cycle(1'b1);
        idle_inputs();
        rec_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rec_valid) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        rec_ready = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        ts_model   = 32'd0;
        exp_q.delete();
        rec_pushed = 0;
        rec_done   = 0;
        check("abort_valid", {63'd0, rec_valid}, 64'd0);
        check("abort_data", rec_data, 64'd0);
        rec_ready = 1'b1;
        en = 1'b1;
        aktv = 4'b1001;
        vals[0] = 64'hAA;
        vals[3] = 64'hBB;
        cycle(1'b1);
        drain();

        // Randomized traffic with backpressure, kept clear of overflow.
        for (int c = 0; c < 400; c++) begin
            en        = ($urandom_range(0, 3) != 0);
            aktv      = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            rec_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) vals[i] = {$urandom, $urandom};
            if (rec_pushed - rec_done >= DEPTH - 1) aktv = 4'd0;
            cycle(1'b1);
        end
        drain();
        check("random_no_drops", {48'd0, drop_count}, 64'd0);

        // Nine records into a stalled eight-deep FIFO.
        do_reset();
        rec_ready = 1'b0;
        en = 1'b1;
        for (int r = 0; r < 9; r++) begin
            aktv = 4'(1 << (r % 4));
            for (int i = 0; i < 4; i++) vals[i] = 64'(100 + r * 4 + i);
            cycle(1'b1);
        end
        idle_inputs();
        check("stall_records", 64'(rec_pushed), 64'd8);
        drain();
        check("overflow_flag", {63'd0, overflow}, {63'd0, exp_drops != 0});
        check("drop_count", {48'd0, drop_count}, 64'(exp_drops));
        check("records_done", 64'(rec_done), 64'(rec_pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
